// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = FSM side (drives control), slave = datapath side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] aluop;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output aluop, alusrca, alusrcb, result_src, adr_src,
           ir_write, pc_write, mem_write, reg_write, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  aluop, alusrca, alusrcb, result_src, adr_src,
           ir_write, pc_write, mem_write, reg_write, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V core (lw, sw, R-type, beq; other opcodes trap).
// Optional macro MC_MEM_WAIT_EN adds memory wait states in FETCH, MEMREAD and MEMWRITE.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_TRAP     = 4'd9;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_ready_w;

`ifdef MC_MEM_WAIT_EN
  assign mem_ready_w = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ready_w      = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready_w ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      // IR is stable since FETCH, so re-reading the opcode here is safe
      S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready_w ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready_w ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic [1:0] aluop;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_update;
  logic       branch;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;

  always_comb begin
    aluop      = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = mem_ready_w;
        pc_update  = mem_ready_w;
        alusrcb    = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
    // Reset masks every output combinationally so strobes drop within the reset cycle
    if (reset) begin
      aluop      = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      result_src = 2'b00;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.aluop      = aluop;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.result_src = result_src;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_update | (branch & bus.zero);
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed literal checks plus a randomized
// run compared every cycle against an instruction-level model (honours MC_MEM_WAIT_EN).
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4;
  localparam int MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, TRAP = 9;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int exp_state = FETCH;
  int plan[$];

  // {state, aluop, alusrca, alusrcb, result_src, adr_src, ir_write, pc_write, mem_write, reg_write, illegal}
  function automatic logic [17:0] expected_outputs(input int st, input logic z, input logic rdy);
    logic [1:0] aop, sa, sb, rs;
    logic adr, irw, pcu, br, mw, rw, ill;
    {aop, sa, sb, rs} = '0;
    {adr, irw, pcu, br, mw, rw, ill} = '0;
    case (st)
      FETCH:    begin irw = 1; pcu = 1; sb = 2'd2; rs = 2'd2; end
      DECODE:   begin sa = 2'd1; sb = 2'd1; end
      MEMADR:   begin sa = 2'd2; sb = 2'd1; end
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 2'd1; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECUTE:  begin sa = 2'd2; aop = 2'd2; end
      ALUWB:    rw = 1;
      BRANCH:   begin sa = 2'd2; aop = 2'd1; br = 1; end
      TRAP:     ill = 1;
      default:  ;
    endcase
    if (WAIT_EN && st == FETCH && !rdy) begin
      irw = 0;
      pcu = 0;
    end
    return {st[3:0], aop, sa, sb, rs, adr, irw, pcu | (br & z), mw, rw, ill};
  endfunction

  function automatic logic [17:0] dut_outputs();
    return {bus.state, bus.aluop, bus.alusrca, bus.alusrcb, bus.result_src, bus.adr_src,
            bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write, bus.illegal};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("outputs_in_reset", {14'd0, dut_outputs()}, 32'd0);
      exp_state = FETCH;
      plan.delete();
    end else begin
      check($sformatf("outputs_st%0d", exp_state), {14'd0, dut_outputs()},
            {14'd0, expected_outputs(exp_state, bus.zero, bus.mem_ready)});
      if (WAIT_EN && !bus.mem_ready &&
          (exp_state == FETCH || exp_state == MEMREAD || exp_state == MEMWRITE)) begin
        // memory not ready: stay
      end else if (exp_state == TRAP) begin
        // sticky until reset
      end else if (exp_state == FETCH) begin
        exp_state = DECODE;
      end else begin
        if (exp_state == DECODE) begin
          plan.delete();
          case (bus.opcode)
            7'b0000011: plan = '{MEMADR, MEMREAD, MEMWB};
            7'b0100011: plan = '{MEMADR, MEMWRITE};
            7'b0110011: plan = '{EXECUTE, ALUWB};
            7'b1100011: plan = '{BRANCH};
            default:    plan = '{TRAP};
          endcase
        end
        exp_state = (plan.size() > 0) ? plan.pop_front() : FETCH;
      end
    end
  end

  // ---------------- directed helpers ----------------
  // seq holds one state per nibble, first state in the lowest nibble
  task automatic run_seq(input string name, input logic [6:0] op, input logic z, input int n,
                         input logic [31:0] seq, output int rw_cnt, output logic [3:0] rw_st,
                         output logic [1:0] rs_rw, output int mw_cnt, output logic adr_mw,
                         output logic pcw_br, output logic [1:0] aluop_ex);
    rw_cnt = 0; mw_cnt = 0; rw_st = 4'hf; rs_rw = 2'b11; adr_mw = 1'b0;
    pcw_br = 1'b0; aluop_ex = 2'b11;
    bus.opcode = op;
    bus.zero   = z;
    #1;
    for (int i = 0; i < n; i++) begin
      check({name, "_state"}, {28'd0, bus.state}, {28'd0, seq[4*i +: 4]});
      if (bus.reg_write) begin rw_cnt++; rw_st = bus.state; rs_rw = bus.result_src; end
      if (bus.mem_write) begin mw_cnt++; adr_mw = bus.adr_src; end
      if (bus.state == 4'd8) pcw_br = bus.pc_write;
      if (bus.state == 4'd6 || bus.state == 4'd8) aluop_ex = bus.aluop;
      if (i < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  int rw_cnt, mw_cnt, ill_cnt, trap_cycles;
  logic [3:0] rw_st;
  logic [1:0] rs_rw, aluop_ex;
  logic adr_mw, pcw_br;
  logic [6:0] legal_ops [4];

  initial begin
    legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011;
    legal_ops[2] = 7'b0110011; legal_ops[3] = 7'b1100011;
    reset = 1'b1; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {28'd0, bus.state}, 32'd0);
    check("reset_strobes", {28'd0, bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write}, 32'd0);
    reset = 1'b0;
    #1;
    check("release_fetch_irw", {31'd0, bus.ir_write}, 32'd1);

    run_seq("lw", 7'b0000011, 1'b0, 6, 32'h043210, rw_cnt, rw_st, rs_rw, mw_cnt, adr_mw, pcw_br, aluop_ex);
    check("lw_rw_cnt", rw_cnt, 1);
    check("lw_rw_state", {28'd0, rw_st}, 32'd4);
    check("lw_rw_src", {30'd0, rs_rw}, 32'd1);

    run_seq("rtype", 7'b0110011, 1'b0, 5, 32'h07610, rw_cnt, rw_st, rs_rw, mw_cnt, adr_mw, pcw_br, aluop_ex);
    check("rtype_aluop", {30'd0, aluop_ex}, 32'd2);
    check("rtype_rw_cnt", rw_cnt, 1);
    check("rtype_rw_state", {28'd0, rw_st}, 32'd7);

    run_seq("beq_t", 7'b1100011, 1'b1, 4, 32'h0810, rw_cnt, rw_st, rs_rw, mw_cnt, adr_mw, pcw_br, aluop_ex);
    check("beq_taken_pcw", {31'd0, pcw_br}, 32'd1);
    check("beq_aluop", {30'd0, aluop_ex}, 32'd1);
    run_seq("beq_nt", 7'b1100011, 1'b0, 4, 32'h0810, rw_cnt, rw_st, rs_rw, mw_cnt, adr_mw, pcw_br, aluop_ex);
    check("beq_not_taken_pcw", {31'd0, pcw_br}, 32'd0);

    run_seq("sw", 7'b0100011, 1'b0, 5, 32'h05210, rw_cnt, rw_st, rs_rw, mw_cnt, adr_mw, pcw_br, aluop_ex);
    check("sw_mw_cnt", mw_cnt, 1);
    check("sw_adr_src", {31'd0, adr_mw}, 32'd1);
    check("sw_rw_cnt", rw_cnt, 0);

    run_seq("trap", 7'b1111111, 1'b0, 3, 32'h910, rw_cnt, rw_st, rs_rw, mw_cnt, adr_mw, pcw_br, aluop_ex);
    ill_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.illegal && bus.state == 4'd9) ill_cnt++;
      @(posedge clk); #1;
    end
    check("trap_illegal_20", ill_cnt, 20);
    reset = 1'b1;
    #1;
    check("trap_reset_state", {28'd0, bus.state}, 32'd0);
    check("trap_reset_illegal", {31'd0, bus.illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;

    // reset in the middle of a store drops mem_write immediately
    bus.opcode = 7'b0100011;
    repeat (3) begin @(posedge clk); #1; end
    check("sw_mid_state", {28'd0, bus.state}, 32'd5);
    check("sw_mid_mw", {31'd0, bus.mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("sw_reset_mw", {31'd0, bus.mem_write}, 32'd0);
    check("sw_reset_state", {28'd0, bus.state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef MC_MEM_WAIT_EN
    bus.opcode = 7'b0100011;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    mw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      if (bus.state == 4'd5 && bus.mem_write) mw_cnt++;
      @(posedge clk); #1;
    end
    check("wait_sw_mw_cycles", mw_cnt, 4);
    check("wait_sw_exit", {28'd0, bus.state}, 32'd0);
    bus.opcode = 7'b0100011;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("wait_sw_reset_mw", {31'd0, bus.mem_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
`endif

    // randomized run, checked every cycle by the model
    trap_cycles = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
      end else if (exp_state == TRAP && ++trap_cycles > 4) begin
        trap_cycles = 0;
        reset = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
      end
      if (exp_state == FETCH)
        bus.opcode = ($urandom_range(0, 19) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 3)];
      bus.zero      = 1'($urandom);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
